// File: rtl/nibble_alu_seq.sv
// nibble_alu_seq: command sequencer and ALU in front of a 4x4 nibble register
// file. It takes one command at a time, reads up to two operands through the
// file's single read port, and writes the 4-bit result back through the write
// port.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE. All command fields
// are captured at that edge and the inputs are ignored until the next IDLE.
//
// Optional feature: define NIBBLE_SEQ_FLAGS_EN to add the registered zero and
// carry flag outputs (flag_z, flag_c).
//
// The FSM state is held in the signal 'state' (type state_t) for observation.

module nibble_alu_seq #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_read_add,
    output logic              rf_read_en,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic [ADDR_W-1:0] rf_write_add,
    output logic              rf_write_en,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              done,
    output logic [DATA_W-1:0] result
`ifdef NIBBLE_SEQ_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_A     = 3'd1,
        RD_B     = 3'd2,
        WR       = 3'd3,
        DONE_NOP = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic              accept;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] src_a_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;

    assign accept = cmd_valid && (state == IDLE);

    // State register; reset drops any command in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and all register-file / handshake outputs from state.
    always_comb begin
        state_next   = state;
        cmd_ready    = 1'b0;
        rf_read_en   = 1'b0;
        rf_read_add  = '0;
        rf_write_en  = 1'b0;
        rf_write_add = '0;
        rf_data_in   = '0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: state_next = RD_A;
                        OP_LDI:                                state_next = WR;
                        default:                               state_next = DONE_NOP;
                    endcase
                end
            end
            RD_A: begin
                rf_read_en  = 1'b1;
                rf_read_add = src_a_q;
                state_next  = (op_q == OP_MOV) ? WR : RD_B;
            end
            RD_B: begin
                rf_read_en  = 1'b1;
                rf_read_add = src_b_q;
                state_next  = WR;
            end
            WR: begin
                rf_write_en  = 1'b1;
                rf_write_add = dst_q;
                rf_data_in   = alu_res;
                done         = 1'b1;
                state_next   = IDLE;
            end
            DONE_NOP: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command capture, operand capture during the read cycles, result on retire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            result  <= '0;
        end else begin
            if (accept) begin
                op_q    <= cmd_op;
                src_a_q <= cmd_src_a;
                src_b_q <= cmd_src_b;
                dst_q   <= cmd_dst;
                imm_q   <= cmd_imm;
            end
            if (state == RD_A) begin
                op_a <= rf_data_out;
            end
            if (state == RD_B) begin
                op_b <= rf_data_out;
            end
            if (state == WR) begin
                result <= alu_res;
            end
        end
    end

    // 4-bit result from the captured operands; wraps modulo 16.
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_MOV:  alu_res = op_a;
            OP_LDI:  alu_res = imm_q;
            default: alu_res = '0;
        endcase
    end

`ifdef NIBBLE_SEQ_FLAGS_EN
    logic alu_carry;

    // Carry for ADD is detected as wrap-around (sum smaller than an addend);
    // for SUB it is the borrow.
    always_comb begin
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD:  alu_carry = (alu_res < op_a);
            OP_SUB:  alu_carry = (op_a < op_b);
            default: alu_carry = 1'b0;
        endcase
    end

    // Flags change only when a result is written; held across NOP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == WR) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_carry;
        end
    end
`endif

endmodule

// File: tb/tb_nibble_alu_seq.sv
// Testbench for nibble_alu_seq: behavioural register file model, scoreboard of
// expected register writes, per-scenario tasks and a final report.

module tb_nibble_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_src_a;
  logic [1:0] cmd_src_b;
  logic [1:0] cmd_dst;
  logic [3:0] cmd_imm;
  logic [1:0] rf_read_add;
  logic       rf_read_en;
  logic [3:0] rf_data_out;
  logic [1:0] rf_write_add;
  logic       rf_write_en;
  logic [3:0] rf_data_in;
  logic       done;
  logic [3:0] result;
`ifdef NIBBLE_SEQ_FLAGS_EN
  logic       flag_z;
  logic       flag_c;
`endif

  // scoreboard: {write address, write data}
  logic [5:0] exp_q[$];
  logic [1:0] rd_log[$];
  logic [3:0] exp_regs[4];
  logic [3:0] exp_result;
  logic       exp_z;
  logic       exp_c;
  logic [3:0] rf_regs[4];
  int         n_tests = 0;
  int         n_fail = 0;

  nibble_alu_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_src_a    (cmd_src_a),
    .cmd_src_b    (cmd_src_b),
    .cmd_dst      (cmd_dst),
    .cmd_imm      (cmd_imm),
    .rf_read_add  (rf_read_add),
    .rf_read_en   (rf_read_en),
    .rf_data_out  (rf_data_out),
    .rf_write_add (rf_write_add),
    .rf_write_en  (rf_write_en),
    .rf_data_in   (rf_data_in),
    .done         (done),
    .result       (result)
`ifdef NIBBLE_SEQ_FLAGS_EN
    ,
    .flag_z       (flag_z),
    .flag_c       (flag_c)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  // register file model: combinational read, write on rising edge
  assign rf_data_out = rf_regs[rf_read_add];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) rf_regs[i] <= '0;
    end else if (rf_write_en) begin
      rf_regs[rf_write_add] <= rf_data_in;
    end
  end

  // monitor: port invariants, read log, scoreboard pop on every write cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rf_read_en) rd_log.push_back(rf_read_add);
      n_tests++;
      if ((rf_read_en && rf_write_en) !== 1'b0) begin
        n_fail++;
        $display("FAIL rw_overlap: read_en=%0b write_en=%0b required not both", rf_read_en, rf_write_en);
      end
      n_tests++;
      if (!rf_read_en && rf_read_add !== 2'd0) begin
        n_fail++;
        $display("FAIL read_add_idle: got %0d required 0", rf_read_add);
      end
      n_tests++;
      if (!rf_write_en && ({rf_write_add, rf_data_in} !== 6'd0)) begin
        n_fail++;
        $display("FAIL write_side_idle: add=%0d data=%0d required 0/0", rf_write_add, rf_data_in);
      end
      if (rf_write_en) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: add=%0d data=%0d required no write", rf_write_add, rf_data_in);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          if ({rf_write_add, rf_data_in} !== e) begin
            n_fail++;
            $display("FAIL write: got add=%0d data=%0d required add=%0d data=%0d",
                     rf_write_add, rf_data_in, e[5:4], e[3:0]);
          end
        end
      end
    end
  end

  // ALU reference: {carry, result}
  function automatic logic [4:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] imm);
    logic [4:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: begin r[3:0] = a - b; r[4] = (a < b); end
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a};
      3'd5: r = {1'b0, imm};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // scoreboard push for a writing command, updates reference state
  task automatic expect_cmd(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [1:0] d, input logic [3:0] imm);
    logic [4:0] m;
    if (op <= 3'd5) begin
      m = alu_model(op, exp_regs[sa], exp_regs[sb], imm);
      exp_q.push_back({d, m[3:0]});
      exp_regs[d] = m[3:0];
      exp_result  = m[3:0];
      exp_z       = (m[3:0] == 4'd0);
      exp_c       = m[4];
    end
  endtask

  // driver: issue one command, return cycles from acceptance edge to done (-1 on timeout)
  task automatic send(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [1:0] d, input logic [3:0] imm, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
    rd_log.delete();
    cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_src_a = 2'($urandom_range(0, 3));
    cmd_src_b = 2'($urandom_range(0, 3));
    cmd_dst   = 2'($urandom_range(0, 3));
    cmd_imm   = 4'($urandom_range(0, 15));
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_dst = 2'd1; cmd_imm = 4'd7;
    cmd_src_a = 2'd0; cmd_src_b = 2'd0;
    for (int i = 0; i < 4; i++) exp_regs[i] = 4'd0;
    exp_result = 4'd0; exp_z = 1'b0; exp_c = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", cmd_ready); end
      n_tests++;
      if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_write_en: got %0b required 0", rf_write_en); end
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b required 0", done); end
      n_tests++;
      if (result !== 4'd0) begin n_fail++; $display("FAIL reset_result: got %0d required 0", result); end
`ifdef NIBBLE_SEQ_FLAGS_EN
      n_tests++;
      if ({flag_z, flag_c} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %0b%0b required 00", flag_z, flag_c); end
`endif
    end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({done, rf_write_en, rf_read_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_no_accept: done/wen/ren=%0b%0b%0b required 000", done, rf_write_en, rf_read_en);
    end
  endtask

  task automatic test_ldi;
    int lat;
    expect_cmd(3'd5, 2'd0, 2'd0, 2'd1, 4'd9);
    send(3'd5, 2'd0, 2'd0, 2'd1, 4'd9, lat);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL ldi1_latency: got %0d required 1", lat); end
    expect_cmd(3'd5, 2'd0, 2'd0, 2'd2, 4'd8);
    send(3'd5, 2'd0, 2'd0, 2'd2, 4'd8, lat);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL ldi2_latency: got %0d required 1", lat); end
    @(negedge clk);
    n_tests++;
    if (result !== 4'd8) begin n_fail++; $display("FAIL ldi_result: got %0d required 8", result); end
  endtask

  task automatic test_add;
    int lat;
    expect_cmd(3'd0, 2'd1, 2'd2, 2'd3, 4'd0);
    send(3'd0, 2'd1, 2'd2, 2'd3, 4'd0, lat);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d required 3", lat); end
    n_tests++;
    if (rd_log.size() != 2 || rd_log[0] !== 2'd1 || rd_log[1] !== 2'd2) begin
      n_fail++;
      $display("FAIL add_reads: got %0d read cycles required 2 (add 1 then 2)", rd_log.size());
    end
    @(negedge clk);
    n_tests++;
    if (result !== 4'd1) begin n_fail++; $display("FAIL add_result: got %0d required 1", result); end
`ifdef NIBBLE_SEQ_FLAGS_EN
    n_tests++;
    if ({flag_z, flag_c} !== 2'b01) begin n_fail++; $display("FAIL add_flags: got z=%0b c=%0b required z=0 c=1", flag_z, flag_c); end
`endif
  endtask

  task automatic test_sub_mov;
    int lat;
    expect_cmd(3'd1, 2'd2, 2'd2, 2'd0, 4'd0);
    send(3'd1, 2'd2, 2'd2, 2'd0, 4'd0, lat);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL sub_latency: got %0d required 3", lat); end
    n_tests++;
    if (rd_log.size() != 2 || rd_log[0] !== 2'd2 || rd_log[1] !== 2'd2) begin
      n_fail++;
      $display("FAIL sub_reads: got %0d read cycles required 2 (add 2 twice)", rd_log.size());
    end
    @(negedge clk);
    n_tests++;
    if (result !== 4'd0) begin n_fail++; $display("FAIL sub_result: got %0d required 0", result); end
`ifdef NIBBLE_SEQ_FLAGS_EN
    n_tests++;
    if ({flag_z, flag_c} !== 2'b10) begin n_fail++; $display("FAIL sub_flags: got z=%0b c=%0b required z=1 c=0", flag_z, flag_c); end
`endif
    expect_cmd(3'd4, 2'd3, 2'd0, 2'd1, 4'd0);
    send(3'd4, 2'd3, 2'd0, 2'd1, 4'd0, lat);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL mov_latency: got %0d required 2", lat); end
    n_tests++;
    if (rd_log.size() != 1 || rd_log[0] !== 2'd3) begin
      n_fail++;
      $display("FAIL mov_reads: got %0d read cycles required 1 (add 3)", rd_log.size());
    end
    @(negedge clk);
    n_tests++;
    if (result !== 4'd1) begin n_fail++; $display("FAIL mov_result: got %0d required 1", result); end
  endtask

  task automatic test_random;
    int lat;
    int exp_lat;
    int exp_rd;
    logic [2:0] op;
    logic [1:0] sa, sb, d;
    logic [3:0] imm;
    for (int i = 0; i < 24; i++) begin
      op  = 3'($urandom_range(0, 7));
      sa  = 2'($urandom_range(0, 3));
      sb  = 2'($urandom_range(0, 3));
      d   = 2'($urandom_range(0, 3));
      imm = 4'($urandom_range(0, 15));
      exp_lat = (op <= 3'd3) ? 3 : (op == 3'd4) ? 2 : 1;
      exp_rd  = (op <= 3'd3) ? 2 : (op == 3'd4) ? 1 : 0;
      expect_cmd(op, sa, sb, d, imm);
      send(op, sa, sb, d, imm, lat);
      n_tests++;
      if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency op=%0d: got %0d required %0d", op, lat, exp_lat); end
      n_tests++;
      if (rd_log.size() != exp_rd) begin n_fail++; $display("FAIL rand_reads op=%0d: got %0d required %0d", op, rd_log.size(), exp_rd); end
      @(negedge clk);
      n_tests++;
      if (result !== exp_result) begin n_fail++; $display("FAIL rand_result op=%0d: got %0d required %0d", op, result, exp_result); end
`ifdef NIBBLE_SEQ_FLAGS_EN
      n_tests++;
      if ({flag_z, flag_c} !== {exp_z, exp_c}) begin
        n_fail++;
        $display("FAIL rand_flags op=%0d: got z=%0b c=%0b required z=%0b c=%0b", op, flag_z, flag_c, exp_z, exp_c);
      end
`endif
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    cmd_op = 3'd0; cmd_src_a = 2'd1; cmd_src_b = 2'd2; cmd_dst = 2'd3; cmd_imm = 4'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({rf_read_en, rf_read_add} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_rd_b: got ren=%0b add=%0d required ren=1 add=2", rf_read_en, rf_read_add);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({cmd_ready, rf_write_en, done} !== 3'b100) begin
      n_fail++;
      $display("FAIL mid_reset_idle: ready/wen/done=%0b%0b%0b required 100", cmd_ready, rf_write_en, done);
    end
    n_tests++;
    if (result !== 4'd0) begin n_fail++; $display("FAIL mid_reset_result: got %0d required 0", result); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_regs[i] = 4'd0;
    exp_result = 4'd0; exp_z = 1'b0; exp_c = 1'b0;
    expect_cmd(3'd5, 2'd0, 2'd0, 2'd0, 4'd5);
    send(3'd5, 2'd0, 2'd0, 2'd0, 4'd5, lat);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL mid_ldi_latency: got %0d required 1", lat); end
    @(negedge clk);
    n_tests++;
    if (result !== 4'd5) begin n_fail++; $display("FAIL mid_ldi_result: got %0d required 5", result); end
  endtask

  task automatic test_back_to_back_nop;
    logic prev_acc;
    logic acc_now;
    int   last_acc;
    int   n_acc;
    last_acc = -10;
    n_acc = 0;
    prev_acc = 1'b0;
    @(negedge clk);
    cmd_op = 3'b110; cmd_src_a = 2'd1; cmd_src_b = 2'd2; cmd_dst = 2'd3; cmd_imm = 4'd15;
    cmd_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      acc_now = cmd_ready;
      n_tests++;
      if (done !== prev_acc) begin n_fail++; $display("FAIL nop_done cycle %0d: got %0b required %0b", k, done, prev_acc); end
      if (acc_now) begin
        n_tests++;
        if (k - last_acc < 2) begin n_fail++; $display("FAIL nop_interval: got %0d required >=2", k - last_acc); end
        last_acc = k;
        n_acc++;
      end
      prev_acc = acc_now;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    n_tests++;
    if (n_acc < 4) begin n_fail++; $display("FAIL nop_accepts: got %0d required >=4", n_acc); end
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (result !== exp_result) begin n_fail++; $display("FAIL nop_result: got %0d required %0d", result, exp_result); end
`ifdef NIBBLE_SEQ_FLAGS_EN
    n_tests++;
    if ({flag_z, flag_c} !== {exp_z, exp_c}) begin
      n_fail++;
      $display("FAIL nop_flags: got z=%0b c=%0b required z=%0b c=%0b", flag_z, flag_c, exp_z, exp_c);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_dst = 2'd0; cmd_imm = 4'd0;
    test_reset();
    test_ldi();
    test_add();
    test_sub_mov();
    test_random();
    test_reset_mid();
    test_back_to_back_nop();
    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL pending_writes: got %0d left required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
